// File: rtl/barrett_reduce_pipe.sv
`default_nettype none
// ============================================================================
// barrett_reduce_pipe : 4-stage Barrett reducer, t = z mod q for a runtime
//                       k-bit modulus, valid/ready with a global stall.
// Revision 1.0
// ============================================================================
module barrett_reduce_pipe #(
  parameter int W     = 64,
  parameter int TAG_W = 8,
  parameter int KW    = $clog2(W + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2*W-1:0]   z,
  input  logic [W-1:0]     q,
  input  logic [W:0]       mu,
  input  logic [KW-1:0]    k,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     t,
  output logic             out_err,
  output logic [TAG_W-1:0] out_tag
);

  localparam int ZW = 2 * W;
  localparam int RW = 2 * W + 1;
  localparam int PW = 3 * W + 2;
  localparam int SW = KW + 1;

  logic w_en;
  assign w_en     = !(out_valid && !out_ready);
  assign in_ready = w_en;

  // Stage 1 registers
  logic             r_v1;
  logic [ZW-1:0]    r_z1;
  logic [ZW-1:0]    r_q1;
  logic [W-1:0]     r_qm1;
  logic [W:0]       r_mu1;
  logic [KW-1:0]    r_k1;
  logic [TAG_W-1:0] r_tag1;
  logic             r_erri1;

  // Stage 2 registers
  logic             r_v2;
  logic [ZW-1:0]    r_z2;
  logic [RW-1:0]    r_q3;
  logic [W-1:0]     r_qm2;
  logic [TAG_W-1:0] r_tag2;
  logic             r_erri2;

  // Stage 3 registers
  logic             r_v3;
  logic [RW-1:0]    r_r3;
  logic [W-1:0]     r_qm3;
  logic [TAG_W-1:0] r_tag3;
  logic             r_erri3;

  // k = 0 wraps the shift amount to all-ones, which still flags the beat
  logic [KW-1:0] w_km1;
  logic          w_err_in;
  assign w_km1    = k - KW'(1);
  assign w_err_in = (k < KW'(2)) || (k > KW'(W)) || ((q >> w_km1) != W'(1));

  logic [PW-1:0] w_prod;
  logic [SW-1:0] w_sh;
  logic [RW-1:0] w_q3;
  assign w_prod = PW'(r_q1) * PW'(r_mu1);
  assign w_sh   = SW'(r_k1) + SW'(1);
  assign w_q3   = RW'(w_prod >> w_sh);

  logic [RW-1:0] w_r;
  assign w_r = RW'(r_z2) - (r_q3 * RW'(r_qm2));

  logic [RW-1:0] w_qe;
  logic [RW-1:0] w_r1;
  logic [RW-1:0] w_r2;
  logic          w_bad;
  assign w_qe  = RW'(r_qm3);
  assign w_r1  = (r_r3 >= w_qe) ? (r_r3 - w_qe) : r_r3;
  assign w_r2  = (w_r1 >= w_qe) ? (w_r1 - w_qe) : w_r1;
  assign w_bad = r_erri3 || (w_r2 >= w_qe);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v1      <= 1'b0;
      r_z1      <= '0;
      r_q1      <= '0;
      r_qm1     <= '0;
      r_mu1     <= '0;
      r_k1      <= '0;
      r_tag1    <= '0;
      r_erri1   <= 1'b0;
      r_v2      <= 1'b0;
      r_z2      <= '0;
      r_q3      <= '0;
      r_qm2     <= '0;
      r_tag2    <= '0;
      r_erri2   <= 1'b0;
      r_v3      <= 1'b0;
      r_r3      <= '0;
      r_qm3     <= '0;
      r_tag3    <= '0;
      r_erri3   <= 1'b0;
      out_valid <= 1'b0;
      t         <= '0;
      out_err   <= 1'b0;
      out_tag   <= '0;
    end else if (w_en) begin
      r_v1      <= in_valid;
      r_v2      <= r_v1;
      r_v3      <= r_v2;
      out_valid <= r_v3;
      if (in_valid) begin
        r_z1    <= z;
        r_q1    <= z >> w_km1;
        r_qm1   <= q;
        r_mu1   <= mu;
        r_k1    <= k;
        r_tag1  <= in_tag;
        r_erri1 <= w_err_in;
      end
      if (r_v1) begin
        r_z2    <= r_z1;
        r_q3    <= w_q3;
        r_qm2   <= r_qm1;
        r_tag2  <= r_tag1;
        r_erri2 <= r_erri1;
      end
      if (r_v2) begin
        r_r3    <= w_r;
        r_qm3   <= r_qm2;
        r_tag3  <= r_tag2;
        r_erri3 <= r_erri2;
      end
      if (r_v3) begin
        t       <= w_bad ? '0 : W'(w_r2);
        out_err <= w_bad;
        out_tag <= r_tag3;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_barrett_reduce_pipe.sv
`default_nettype none
// ============================================================================
// tb_barrett_reduce_pipe : scoreboard bench for barrett_reduce_pipe (W=64).
// Revision 1.0
// ============================================================================
module tb_barrett_reduce_pipe;

  localparam int W     = 64;
  localparam int TAG_W = 8;
  localparam int KW    = $clog2(W + 1);
  localparam int ZW    = 2 * W;
  localparam int RW    = 2 * W + 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [ZW-1:0]    z = '0;
  logic [W-1:0]     q = '0;
  logic [W:0]       mu = '0;
  logic [KW-1:0]    k = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [W-1:0]     t;
  logic             out_err;
  logic [TAG_W-1:0] out_tag;

  int checks = 0;
  int errors = 0;
  bit rand_rdy = 1'b0;

  typedef struct packed {
    logic [W-1:0]     t;
    logic             err;
    logic [TAG_W-1:0] tag;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  barrett_reduce_pipe #(.W(W), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .z(z), .q(q), .mu(mu), .k(k), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .t(t),
    .out_err(out_err), .out_tag(out_tag)
  );

  task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  function automatic exp_t mk(input logic [W-1:0] tt, input logic ee, input logic [TAG_W-1:0] tg);
    exp_t e;
    e.t = tt; e.err = ee; e.tag = tg;
    return e;
  endfunction

  // Reference: legal iff 2 <= k <= W and 2^(k-1) <= q < 2^k; then t = z mod q
  function automatic exp_t model(input logic [ZW-1:0] zz, input logic [W-1:0] qq,
                                 input logic [KW-1:0] kk, input logic [TAG_W-1:0] tg);
    exp_t e;
    int ki;
    logic [W:0] lo, hi;
    ki = int'(kk);
    e.tag = tg;
    e.t   = '0;
    e.err = 1'b1;
    if (ki >= 2 && ki <= W) begin
      lo = (W+1)'(1) << (ki - 1);
      hi = (W+1)'(1) << ki;
      if ((W+1)'(qq) >= lo && (W+1)'(qq) < hi) begin
        e.err = 1'b0;
        e.t   = W'(zz % ZW'(qq));
      end
    end
    return e;
  endfunction

  function automatic logic [W:0] mu_of(input logic [W-1:0] qq, input int ki);
    logic [RW-1:0] num;
    num = '0;
    num[2*ki] = 1'b1;
    return (W+1)'(num / RW'(qq));
  endfunction

  function automatic logic [W-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic send(input logic [ZW-1:0] zz, input logic [W-1:0] qq, input logic [W:0] mm,
                      input logic [KW-1:0] kk, input logic [TAG_W-1:0] tg, input exp_t e);
    logic acc;
    acc = 1'b0;
    in_valid = 1'b1; z = zz; q = qq; mu = mm; k = kk; in_tag = tg;
    for (int n = 0; n < 200 && !acc; n++) begin
      @(negedge clk);
      acc = in_ready && !rst;
      if (acc) exp_q.push_back(e);
      @(posedge clk);
      #1;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got no accept expected accept of tag %0h", tg);
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic lat_beat(input logic [ZW-1:0] zz, input logic [W-1:0] qq, input logic [W:0] mm,
                          input logic [KW-1:0] kk, input logic [TAG_W-1:0] tg, input exp_t e);
    int n;
    send(zz, qq, mm, kk, tg, e);
    in_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 20);
    chk("latency", n, 4);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_empty", exp_q.size(), 0);
  endtask

  task automatic gen_legal(output logic [ZW-1:0] zz, output logic [W-1:0] qq,
                           output logic [W:0] mm, output logic [KW-1:0] kk);
    int ki;
    logic [W:0] lo;
    logic [ZW-1:0] rz, q2;
    ki = int'($urandom_range(2, W));
    lo = (W+1)'(1) << (ki - 1);
    qq = W'(lo | ((W+1)'(rnd64()) & (lo - 1)));
    q2 = ZW'(qq) * ZW'(qq);
    rz = {rnd64(), rnd64()};
    zz = rz % q2;
    mm = mu_of(qq, ki);
    kk = KW'(ki);
  endtask

  // Scoreboard and flow-control monitor, sampled mid-cycle
  initial begin : mon
    exp_t e;
    logic ps;
    logic [W-1:0] pt;
    logic pe;
    logic [TAG_W-1:0] ptg;
    ps = 1'b0; pt = '0; pe = 1'b0; ptg = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        ps = 1'b0;
      end else begin
        chk("in_ready", in_ready, !(out_valid && !out_ready));
        if (ps) begin
          chk("hold_valid", out_valid, 1);
          chk("hold_t", t, pt);
          chk("hold_err", out_err, pe);
          chk("hold_tag", out_tag, ptg);
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat: got tag %0h t %0h expected no beat", out_tag, t);
          end else begin
            e = exp_q.pop_front();
            chk("t", t, e.t);
            chk("out_err", out_err, e.err);
            chk("out_tag", out_tag, e.tag);
          end
        end
        ps = out_valid && !out_ready;
        pt = t; pe = out_err; ptg = out_tag;
      end
    end
  end

  initial begin : rdy_gen
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin : main
    logic [ZW-1:0] zz, zf;
    logic [W-1:0]  qq, qf;
    logic [W:0]    mm, muf;
    logic [KW-1:0] kk;
    exp_t e;
    int kind;

    qf  = 64'hFFFF_FFFF_FFFF_FFC5;
    muf = 65'h1_0000_0000_0000_003B;
    zf  = ZW'(qf - 1) * ZW'(qf - 1);

    // Pin the reference against hand-computed values
    e = model(3651363, 7681, 13, 8'h11);
    chk("model_pin_t", e.t, 2888);
    chk("model_pin_err", e.err, 0);
    chk("mu_pin_13", mu_of(7681, 13), 8736);
    chk("mu_pin_64", mu_of(qf, 64), muf);
    e = model(zf, qf, 64, 8'h44);
    chk("model_pin_fw", e.t, 1);
    e = model(100, 3000, 13, 8'h00);
    chk("model_pin_bad", e.err, 1);

    #2;
    chk("rst_valid", out_valid, 0);
    chk("rst_t", t, 0);
    chk("rst_err", out_err, 0);
    chk("rst_tag", out_tag, 0);
    chk("rst_ready", in_ready, 1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    lat_beat(3651363, 7681, 8736, 13, 8'h11, mk(2888, 1'b0, 8'h11));

    send(0,        7681, 8736, 13, 8'h21, mk(0,    1'b0, 8'h21));
    send(58997760, 7681, 8736, 13, 8'h22, mk(7680, 1'b0, 8'h22));
    send(7681,     7681, 8736, 13, 8'h23, mk(0,    1'b0, 8'h23));
    send(zf,       qf,   muf,  64, 8'h44, mk(1,    1'b0, 8'h44));
    send(12345,    0,    8736, 13, 8'h31, mk(0,    1'b1, 8'h31));
    send(12345,    3000, 8736, 13, 8'h32, mk(0,    1'b1, 8'h32));
    send(0,        1,    4,    1,  8'h33, mk(0,    1'b1, 8'h33));
    send(3651363,  7681, 8736, 13, 8'h34, mk(2888, 1'b0, 8'h34));
    idle(1);
    drain();

    // Backpressure burst with a 3-cycle stall once results start emerging
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          zz = ZW'($urandom_range(0, 58997760));
          send(zz, 7681, 8736, 13, TAG_W'(i), model(zz, 7681, 13, TAG_W'(i)));
        end
        in_valid = 1'b0;
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    idle(1);
    drain();

    // Asynchronous reset with three beats in flight
    for (int i = 0; i < 3; i++) begin
      gen_legal(zz, qq, mm, kk);
      send(zz, qq, mm, kk, TAG_W'(8'h50 + i), model(zz, qq, kk, TAG_W'(8'h50 + i)));
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("pre_rst_valid", out_valid, 1);
    #3;
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_t", t, 0);
    chk("async_rst_err", out_err, 0);
    chk("async_rst_tag", out_tag, 0);
    chk("async_rst_ready", in_ready, 1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    idle(8);
    chk("no_stale_valid", out_valid, 0);
    lat_beat(3651363, 7681, 8736, 13, 8'h66, mk(2888, 1'b0, 8'h66));
    idle(1);
    drain();

    // Randomized traffic with random backpressure and occasional illegal beats
    rand_rdy = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        kind = int'($urandom_range(0, 2));
        zz = {rnd64(), rnd64()};
        mm = (W+1)'(rnd64());
        if (kind == 0) begin
          kk = KW'($urandom_range(0, 1));
          qq = rnd64();
        end else if (kind == 1) begin
          kk = KW'($urandom_range(W + 1, (1 << KW) - 1));
          qq = rnd64();
        end else begin
          kk = KW'($urandom_range(2, W));
          qq = rnd64() & ((W'(1) << (kk - 1)) - 1);
        end
      end else begin
        gen_legal(zz, qq, mm, kk);
      end
      send(zz, qq, mm, kk, TAG_W'(i), model(zz, qq, kk, TAG_W'(i)));
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
    end
    in_valid = 1'b0;
    rand_rdy = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/barrett_reduce_pipe.md
# barrett_reduce_pipe

Pipelined, parametrised Barrett modular reducer computing t = z mod q for a runtime modulus q of bit-length k ≤ W, with precomputed mu = floor(4^k / q) supplied by the caller. It generalises the fixed-width single-shot Barrett_Reduction to any width W and a runtime k, and accepts one operand per cycle. It adds valid/ready flow control with backpressure, a sideband tag and an input-error flag. It sits between the vedic multiplier output (2W-bit product) and the modular-arithmetic consumers.

## Interface
- W, default 64: modulus width in bits (W ≥ 4).
- TAG_W, default 8: sideband tag width, passed through unchanged.
- KW, default $clog2(W+1): width of the k port (derived; do not override).
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  operand beat present.
- in_ready  out  1  block accepts a beat this cycle.
- z  in  2W  dividend; must satisfy z < q².
- q  in  W  modulus, bit-length exactly k.
- mu  in  W+1  floor(2^(2k) / q).
- k  in  KW  bit-length of q, legal range 2..W.
- in_tag  in  TAG_W  sideband tag.
- out_valid  out  1  result beat present.
- out_ready  in  1  consumer accepts the result.
- t  out  W  z mod q (0 when out_err=1).
- out_err  out  1  illegal operands for this beat.
- out_tag  out  TAG_W  tag of this beat.

## Operation
- Accept on in_valid && in_ready; deliver on out_valid && out_ready.
- S1 (capture): register z, q, mu, k and tag. Compute q1 = z >> (k−1). Compute err_in = (k<2) | (k>W) | (q>>(k−1) != 1); the last term also covers q=0.
- S2: q3 = (q1 · mu) >> (k+1). The product is held at full 3W+2 bits before the shift.
- S3: r = z − q3·q, evaluated in 2W+1 bits. Barrett guarantees 0 ≤ r < 3q for legal operands.
- S4 (correction): subtract q when r ≥ q, at most twice. If r ≥ q still holds after two subtractions, set err. t = err ? 0 : r[W−1:0]. out_err = err_in | err.
- Behaviour for z ≥ q² is unspecified. The output must still be a deterministic registered value, and the pipeline must not hang.
- Tags travel with their data. Results emerge strictly in input order.

## Timing
- Latency is 4 cycles from the accept edge to out_valid, with no stall.
- Throughput is 1 beat per cycle.
- Global stall: en = !(out_valid && !out_ready). All four stages, including their valid bits, advance only when en=1.
- in_ready = en. This is combinational from out_valid/out_ready; in_ready must not depend on in_valid.
- While stalled, out_valid, t, out_err and out_tag hold stable.
- Bubbles propagate as invalid stages. No stage is collapsed.
- Reset (asynchronous, any cycle) clears every stage valid bit. Outputs after reset: out_valid=0, t=0, out_err=0, out_tag=0. in_ready=1.
- Reset asserted mid-stream discards all in-flight beats, and none reappear after release.
- Simultaneous accept and deliver with en=1 is legal. The pipeline holds 4 beats at steady state.
- Once reset is deasserted, the first beat can be accepted on the next rising edge.

## Test plan
- W=64: z=3651363, q=7681, k=13, mu=8736, tag=0x11 -> t=2888, out_err=0, out_tag=0x11, out_valid exactly 4 cycles after accept.
- Boundaries, same q/k/mu: z=0 -> t=0; z=58997760 (q²−1) -> t=7680; z=7681 -> t=0.
- W=64: q=2^64−59, k=64, mu=2^64+59, z=(q−1)² -> t=1. This exercises full-width k and the W+1-bit mu.
- Errors: q=0, k=13 -> out_err=1, t=0. q=3000, k=13 -> out_err=1. k=1 -> out_err=1. A legal beat following these -> out_err=0 with the correct t.
- Backpressure: stream 8 beats back-to-back with tags 0..7 and hold out_ready=0 for 3 cycles mid-stream. Required: in_ready=0 exactly while out_valid && !out_ready, t/tag held stable, all 8 results correct and delivered in order with no duplicates.
- Reset mid-stream: assert rst asynchronously with 3 beats in flight. Required: out_valid drops immediately and t=0, and no stale beat appears after release. Then 1 new beat -> correct result at latency 4.
